// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Latency: n/a (package); backpressure: n/a.
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // True when addr names the hardwired-zero register.
    function automatic logic zero_mask(input logic [31:0] addr, input logic zero_reg);
        return zero_reg && (addr == 32'd0);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard bundle between issue/writeback (master) and the register file (slave).
// Latency: n/a (wiring only); backpressure: none, every port is accepted each cycle.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int RAWIDTH = REG_AW,
    parameter int DWIDTH  = XLEN,
    parameter int NRD     = 2,
    parameter int NWR     = 2
);

    logic [NRD*RAWIDTH-1:0] AddrR;
    logic [NRD*DWIDTH-1:0]  DataR;
    logic [NRD-1:0]         BusyR;
    logic [NWR-1:0]         WEn;
    logic [NWR*RAWIDTH-1:0] AddrW;
    logic [NWR*DWIDTH-1:0]  DataW;
    logic                   SbSet;
    logic [RAWIDTH-1:0]     SbAddr;
    logic                   SbFlush;

    modport master (
        output AddrR, WEn, AddrW, DataW, SbSet, SbAddr, SbFlush,
        input  DataR, BusyR
    );

    modport slave (
        input  AddrR, WEn, AddrW, DataW, SbSet, SbAddr, SbFlush,
        output DataR, BusyR
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared by writeback, wiped by flush.
// Latency: set/clear visible one cycle later; backpressure: none.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int RAWIDTH  = REG_AW,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NWR-1:0]          wen,
    input  logic [NWR*RAWIDTH-1:0]  addr_w,
    input  logic                    sb_set,
    input  logic [RAWIDTH-1:0]      sb_addr,
    input  logic                    sb_flush,
    output logic [2**RAWIDTH-1:0]   busy
);

    localparam int NREG = 2**RAWIDTH;

    logic [NREG-1:0] busy_nxt;

    // Later assignments override earlier ones, giving flush > set > write-clear.
    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < NWR; w++) begin
            if (wen[w]) begin
                busy_nxt[addr_w[w*RAWIDTH +: RAWIDTH]] = 1'b0;
            end
        end
        if (sb_set && !zero_mask(32'(sb_addr), ZERO_REG != 0)) begin
            busy_nxt[sb_addr] = 1'b1;
        end
        if (sb_flush) begin
            busy_nxt = '0;
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and busy scoreboard.
// Latency: reads combinational, writes next cycle (same cycle via bypass); backpressure: none.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int RAWIDTH  = REG_AW,
    parameter int DWIDTH   = XLEN,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);

    localparam int NREG = 2**RAWIDTH;

    logic [DWIDTH-1:0]  regs    [NREG];
    logic [NREG-1:0]    busy;
    logic [RAWIDTH-1:0] addr_w  [NWR];
    logic [DWIDTH-1:0]  data_w  [NWR];
    logic [RAWIDTH-1:0] addr_r  [NRD];
    logic [DWIDTH-1:0]  rd_dat  [NRD];
    logic               rd_bsy  [NRD];

    always_comb begin
        for (int w = 0; w < NWR; w++) begin
            addr_w[w] = bus.AddrW[w*RAWIDTH +: RAWIDTH];
            data_w[w] = bus.DataW[w*DWIDTH +: DWIDTH];
        end
        for (int i = 0; i < NRD; i++) begin
            addr_r[i] = bus.AddrR[i*RAWIDTH +: RAWIDTH];
        end
    end

    // Ports are visited in ascending order so the highest-index writer lands last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (bus.WEn[w] && !zero_mask(32'(addr_w[w]), ZERO_REG != 0)) begin
                    regs[addr_w[w]] <= data_w[w];
                end
            end
        end
    end

    rf_scoreboard #(
        .RAWIDTH  (RAWIDTH),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wen      (bus.WEn),
        .addr_w   (bus.AddrW),
        .sb_set   (bus.SbSet),
        .sb_addr  (bus.SbAddr),
        .sb_flush (bus.SbFlush),
        .busy     (busy)
    );

    // Bypass is suppressed in reset so outputs read zero while rst_n is low.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_dat[i] = regs[addr_r[i]];
            rd_bsy[i] = busy[addr_r[i]];
            if ((BYPASS != 0) && rst_n) begin
                for (int w = 0; w < NWR; w++) begin
                    if (bus.WEn[w] && (addr_w[w] == addr_r[i])) begin
                        rd_dat[i] = data_w[w];
                        rd_bsy[i] = 1'b0;
                    end
                end
            end
            if (zero_mask(32'(addr_r[i]), ZERO_REG != 0)) begin
                rd_dat[i] = '0;
                rd_bsy[i] = 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign bus.DataR[i*DWIDTH +: DWIDTH] = rd_dat[i];
        assign bus.BusyR[i]                  = rd_bsy[i];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regfile_mp_if b0 ();
    regfile_mp_if b1 ();

    assign b1.AddrR   = b0.AddrR;
    assign b1.WEn     = b0.WEn;
    assign b1.AddrW   = b0.AddrW;
    assign b1.DataW   = b0.DataW;
    assign b1.SbSet   = b0.SbSet;
    assign b1.SbAddr  = b0.SbAddr;
    assign b1.SbFlush = b0.SbFlush;

    regfile_mp #(.BYPASS(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    regfile_mp #(.BYPASS(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        b0.WEn     = '0;
        b0.AddrW   = '0;
        b0.DataW   = '0;
        b0.SbSet   = 1'b0;
        b0.SbAddr  = '0;
        b0.SbFlush = 1'b0;
    endtask

    task automatic rd(input int a0, input int a1);
        b0.AddrR = {5'(a1), 5'(a0)};
    endtask

    task automatic wr(input int port, input int a, input logic [31:0] d);
        b0.WEn[port]              = 1'b1;
        b0.AddrW[port*5 +: 5]     = 5'(a);
        b0.DataW[port*32 +: 32]   = d;
    endtask

    task automatic sbset(input int a);
        b0.SbSet  = 1'b1;
        b0.SbAddr = 5'(a);
    endtask

    // Move to the next falling edge and clear all write-side inputs.
    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rd(5, 0);
        #2;
        chk("reset_data", b0.DataR[31:0], 32'h0);
        chk("reset_busy", 32'(b0.BusyR), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write x5 and reserve it in the same cycle: set must win.
        next_cycle();
        wr(0, 5, 32'hDEADBEEF);
        sbset(5);
        rd(5, 0);
        #1;
        chk("byp_x5_data", b0.DataR[31:0], 32'hDEADBEEF);
        chk("byp_x5_busy", 32'(b0.BusyR[0]), 32'h0);
        chk("nobyp_x5_old", b1.DataR[31:0], 32'h0);
        next_cycle();
        #1;
        chk("x5_data", b0.DataR[31:0], 32'hDEADBEEF);
        chk("x5_set_wins", 32'(b0.BusyR[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x5_data", b0.DataR[31:0], 32'h0);
        chk("arst_busy", 32'(b0.BusyR), 32'h0);
        chk("arst_x5_nobyp", b1.DataR[31:0], 32'h0);
        #1 rst_n = 1'b1;

        // Both write ports target x7: port 1 wins.
        next_cycle();
        wr(0, 7, 32'h11);
        wr(1, 7, 32'h22);
        rd(7, 5);
        #1;
        chk("dual_byp", b0.DataR[31:0], 32'h22);
        chk("x5_after_rst", b0.DataR[63:32], 32'h0);
        next_cycle();
        #1;
        chk("dual_x7", b0.DataR[31:0], 32'h22);
        chk("dual_x7_nobyp", b1.DataR[31:0], 32'h22);

        // Bypass vs. no-bypass on x3, both read ports.
        next_cycle();
        wr(0, 3, 32'hA5A5A5A5);
        rd(3, 3);
        #1;
        chk("byp_x3_p0", b0.DataR[31:0], 32'hA5A5A5A5);
        chk("byp_x3_p1", b0.DataR[63:32], 32'hA5A5A5A5);
        chk("nobyp_x3_old", b1.DataR[31:0], 32'h0);
        next_cycle();
        #1;
        chk("nobyp_x3_new", b1.DataR[63:32], 32'hA5A5A5A5);

        // Hardwired zero register.
        next_cycle();
        wr(0, 0, 32'h1234);
        sbset(0);
        rd(0, 0);
        #1;
        chk("x0_byp_data", b0.DataR[31:0], 32'h0);
        chk("x0_byp_busy", 32'(b0.BusyR), 32'h0);
        next_cycle();
        #1;
        chk("x0_data", b0.DataR[31:0], 32'h0);
        chk("x0_data_nobyp", b1.DataR[31:0], 32'h0);
        chk("x0_busy", 32'(b0.BusyR), 32'h0);

        // Scoreboard lifecycle on x9.
        next_cycle();
        sbset(9);
        rd(0, 9);
        #1;
        chk("sb_c1", 32'(b0.BusyR[1]), 32'h0);
        next_cycle();
        #1;
        chk("sb_c2", 32'(b0.BusyR[1]), 32'h1);
        next_cycle();
        #1;
        chk("sb_c3_nobyp", 32'(b1.BusyR[1]), 32'h1);
        next_cycle();
        wr(0, 9, 32'h99);
        #1;
        chk("sb_c4_byp", 32'(b0.BusyR[1]), 32'h0);
        chk("sb_c4_nobyp", 32'(b1.BusyR[1]), 32'h1);
        chk("sb_c4_data", b0.DataR[63:32], 32'h99);
        next_cycle();
        #1;
        chk("sb_c5_byp", 32'(b0.BusyR[1]), 32'h0);
        chk("sb_c5_nobyp", 32'(b1.BusyR[1]), 32'h0);
        chk("sb_c5_data", b1.DataR[63:32], 32'h99);
        next_cycle();
        wr(1, 9, 32'h77);
        sbset(9);
        next_cycle();
        #1;
        chk("sb_set_vs_wr", 32'(b1.BusyR[1]), 32'h1);
        chk("sb_set_vs_wr_data", b1.DataR[63:32], 32'h77);

        // Flush beats a simultaneous set.
        next_cycle();
        sbset(1);
        next_cycle();
        sbset(2);
        next_cycle();
        sbset(3);
        next_cycle();
        rd(1, 2);
        #1;
        chk("pre_flush", 32'(b0.BusyR), 32'h3);
        next_cycle();
        b0.SbFlush = 1'b1;
        sbset(4);
        #1;
        chk("flush_cycle", 32'(b1.BusyR), 32'h3);
        next_cycle();
        #1;
        chk("post_flush_12", 32'(b0.BusyR), 32'h0);
        rd(3, 4);
        #1;
        chk("post_flush_34", 32'(b0.BusyR), 32'h0);
        rd(9, 0);
        #1;
        chk("post_flush_9", 32'(b1.BusyR[0]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
